// File: rtl/fetch_prefetch_unit.sv
// MIPS fetch stage: PC generation, synchronous instruction RAM, prefetch queue with valid/ready delivery.
// Optional single-step debug support is enabled by defining FETCH_STEP_EN.
module fetch_prefetch_unit #(
  parameter int                 NB_BITS     = 32,
  parameter int                 RAM_DEPTH   = 10,
  parameter int                 QUEUE_DEPTH = 4,
  parameter logic [NB_BITS-1:0] RESET_PC    = '0,
  parameter logic [NB_BITS-1:0] NOP_INSTR   = '0,
  parameter                     INIT_FILE   = ""
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enb,
  input  logic                          i_ctr_beq,
  input  logic [NB_BITS-1:0]            i_brq_addr,
  input  logic                          i_ctr_jmp,
  input  logic [NB_BITS-1:0]            i_jmp_addr,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [NB_BITS-1:0]            o_pc,
  output logic [NB_BITS-1:0]            o_instr,
  input  logic                          i_wr_en,
  input  logic [RAM_DEPTH-1:0]          i_wr_addr,
  input  logic [NB_BITS-1:0]            i_wr_data,
  input  logic                          i_step,
  output logic [NB_BITS-1:0]            o_pc_cur,
  output logic [NB_BITS-1:0]            o_cycles,
  output logic [$clog2(QUEUE_DEPTH):0]  o_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [NB_BITS-1:0] r_mem [0:(1<<RAM_DEPTH)-1];
  logic [NB_BITS-1:0] r_rdata;
  logic [NB_BITS-1:0] r_q_pc    [QUEUE_DEPTH];
  logic [NB_BITS-1:0] r_q_instr [QUEUE_DEPTH];

  logic [NB_BITS-1:0] r_pc;
  logic [NB_BITS-1:0] r_infl_tag;
  logic               r_infl;
  logic [PW-1:0]      r_rptr;
  logic [PW-1:0]      r_wptr;
  logic [CW-1:0]      r_count;
  logic [NB_BITS-1:0] r_cycles;
  logic               r_valid;
  logic [NB_BITS-1:0] r_o_pc;
  logic [NB_BITS-1:0] r_o_instr;

  logic               w_active;
  logic               w_redirect;
  logic [NB_BITS-1:0] w_target;
  logic               w_pop;
  logic               w_push;
  logic               w_issue;
  logic [CW:0]        w_need;
  logic [PW-1:0]      w_rptr_n;
  logic [PW-1:0]      w_wptr_n;
  logic [CW-1:0]      w_count_n;
  logic [NB_BITS-1:0] w_head_pc;
  logic [NB_BITS-1:0] w_head_instr;

`ifdef FETCH_STEP_EN
  logic r_step_d;

  // Registered copy of i_step for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= i_step;
    end
  end

  assign w_active = i_enb | (i_step & ~r_step_d);
`else
  logic w_unused_step;
  assign w_unused_step = i_step;
  assign w_active      = i_enb;
`endif

  // Redirect, issue and queue pointer next-state decode.
  always_comb begin
    w_redirect = i_ctr_jmp | i_ctr_beq;
    w_target   = (i_ctr_jmp ? i_jmp_addr : i_brq_addr) & ~(NB_BITS'(3));
    w_pop      = r_valid & i_ready;
    w_push     = r_infl & ~w_redirect;
    w_need     = {1'b0, r_count} + (CW+1)'(r_infl) + (CW+1)'(1);
    w_issue    = ~w_redirect & (w_need <= (CW+1)'(QUEUE_DEPTH));
    w_rptr_n   = r_rptr + PW'(w_pop);
    w_wptr_n   = r_wptr + PW'(w_push);
    w_count_n  = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Next head entry; a word pushed into a drained queue bypasses storage.
  always_comb begin
    w_head_pc    = '0;
    w_head_instr = NOP_INSTR;
    if (w_count_n != '0) begin
      if (w_push && (r_wptr == w_rptr_n)) begin
        w_head_pc    = r_infl_tag;
        w_head_instr = r_rdata;
      end else begin
        w_head_pc    = r_q_pc[w_rptr_n];
        w_head_instr = r_q_instr[w_rptr_n];
      end
    end else begin
      w_head_pc    = '0;
      w_head_instr = NOP_INSTR;
    end
  end

  // Instruction RAM: loader writes always land; reads see pre-write data.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (w_active && w_issue) begin
      r_rdata <= r_mem[r_pc[RAM_DEPTH+1:2]];
    end
  end

  // Prefetch queue storage.
  always_ff @(posedge i_clk) begin
    if (w_active && w_push) begin
      r_q_pc[r_wptr]    <= r_infl_tag;
      r_q_instr[r_wptr] <= r_rdata;
    end
  end

  // Fetch control, queue bookkeeping and registered head outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc       <= RESET_PC;
      r_infl_tag <= '0;
      r_infl     <= 1'b0;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_cycles   <= '0;
      r_valid    <= 1'b0;
      r_o_pc     <= '0;
      r_o_instr  <= NOP_INSTR;
    end else if (w_active) begin
      r_cycles <= r_cycles + NB_BITS'(1);
      if (w_redirect) begin
        r_pc      <= w_target;
        r_infl    <= 1'b0;
        r_rptr    <= '0;
        r_wptr    <= '0;
        r_count   <= '0;
        r_valid   <= 1'b0;
        r_o_pc    <= '0;
        r_o_instr <= NOP_INSTR;
      end else begin
        if (w_issue) begin
          r_pc       <= r_pc + NB_BITS'(4);
          r_infl_tag <= r_pc + NB_BITS'(4);
          r_infl     <= 1'b1;
        end else begin
          r_infl     <= 1'b0;
        end
        r_rptr    <= w_rptr_n;
        r_wptr    <= w_wptr_n;
        r_count   <= w_count_n;
        r_valid   <= (w_count_n != '0);
        r_o_pc    <= w_head_pc;
        r_o_instr <= w_head_instr;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_pc     = r_o_pc;
  assign o_instr  = r_o_instr;
  assign o_pc_cur = r_pc;
  assign o_cycles = r_cycles;
  assign o_count  = r_count;

endmodule
